// File: rtl/midi_pkg.sv
// midi_pkg -- shared types and constants for the preset sender slice.
//
// Holds the sender FSM state enum, the MIDI program-change status nibble,
// the default preset count, the slot-index and 7-bit MIDI data typedefs, and
// a helper that builds a program-change status byte for a given channel.

package midi_pkg;

  // Upper nibble of a MIDI Program Change status byte.
  localparam logic [3:0] MIDI_PC_STATUS = 4'hC;

  // Default number of preset slots (slots are numbered 1..NUM_PRESETS).
  localparam int DEFAULT_NUM_PRESETS = 4;

  // Slot number as carried on btn_index / active_slot; 0 means "no slot".
  typedef logic [2:0] preset_idx_t;

  // MIDI data bytes carry 7 significant bits.
  typedef logic [6:0] midi_data_t;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_STATUS = 2'd1,
    SEND_DATA   = 2'd2
  } sender_state_t;

  function automatic logic [7:0] pc_status_byte(input logic [3:0] channel);
    return {MIDI_PC_STATUS, channel};
  endfunction

endpackage

// File: rtl/preset_ram.sv
// preset_ram -- NUM_PRESETS x 7-bit preset register file.
//
// Slots are addressed by their 1-based slot number; an address of 0 or one
// beyond NUM_PRESETS selects nothing (write ignored, read returns 0).
// Reset loads slot n with program n-1.
//
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (reloads default programs)
//   we     in   write enable
//   waddr  in   slot number to write (1..NUM_PRESETS)
//   wdata  in   7-bit program number to store
//   raddr  in   slot number to read (1..NUM_PRESETS)
//   rdata  out  combinational read data for raddr

module preset_ram
  import midi_pkg::*;
#(
  parameter int NUM_PRESETS = DEFAULT_NUM_PRESETS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  preset_idx_t waddr,
  input  midi_data_t  wdata,
  input  preset_idx_t raddr,
  output midi_data_t  rdata
);

  midi_data_t mem [NUM_PRESETS];

  // Storage: entry i backs slot i+1. Matching the slot number per entry keeps
  // the address decode independent of how NUM_PRESETS relates to 2**3.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_PRESETS; i++) begin
        mem[i] <= midi_data_t'(i);
      end
    end else if (we) begin
      for (int i = 0; i < NUM_PRESETS; i++) begin
        if (waddr == preset_idx_t'(i + 1)) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // Combinational read port.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_PRESETS; i++) begin
      if (raddr == preset_idx_t'(i + 1)) begin
        rdata = mem[i];
      end
    end
  end

endmodule

// File: rtl/preset_sender.sv
// preset_sender -- stores learned MIDI program numbers into preset slots and
// recalls them by sending a MIDI Program Change (status + data byte) to a
// UART transmitter over a valid/ready handshake.
//
// Optional feature macro: PRESET_RUNNING_STATUS_EN
//   When defined, a recall skips the status byte if the last status byte
//   sent since reset already equals the program-change status for this
//   channel (MIDI running status). Undefined: every recall sends both bytes.
//
// Ports:
//   clk            in   sole clock
//   rst            in   synchronous active-high reset
//   btn_index      in   one-cycle slot select, 0 = none
//   save_mode      in   1: btn_index stores, 0: btn_index recalls
//   midi_pc_valid  in   one-cycle strobe for a received program change
//   midi_pc        in   received program number
//   tx_data        out  MIDI byte offered to the transmitter
//   tx_valid       out  high while tx_data is offered
//   tx_ready       in   transmitter accepts tx_data
//   active_slot    out  last stored or recalled slot, 0 = none
//   busy           out  high whenever the FSM is not IDLE

module preset_sender
  import midi_pkg::*;
#(
  parameter logic [3:0] MIDI_CHANNEL = 4'd0,
  parameter int         NUM_PRESETS  = DEFAULT_NUM_PRESETS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_index,
  input  logic       save_mode,
  input  logic       midi_pc_valid,
  input  logic [6:0] midi_pc,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [2:0] active_slot,
  output logic       busy
);

  localparam logic [7:0]  STATUS_BYTE = pc_status_byte(MIDI_CHANNEL);
  localparam preset_idx_t MAX_SLOT    = preset_idx_t'(NUM_PRESETS);

  sender_state_t state;

  midi_data_t learned_pc;
  logic       learned_ok;
  midi_data_t latched_val;
  midi_data_t slot_rdata;

  logic btn_ok;
  logic store_req;
  logic recall_req;
  logic tx_fire;
  logic skip_status;

  // Buttons only act in IDLE, so anything pressed while busy is simply lost.
  assign btn_ok     = (btn_index != '0) && (btn_index <= MAX_SLOT);
  assign store_req  = (state == IDLE) && btn_ok && save_mode && learned_ok;
  assign recall_req = (state == IDLE) && btn_ok && !save_mode;
  assign tx_fire    = tx_valid && tx_ready;
  assign busy       = (state != IDLE);

  // The store writes the learned_pc register value, i.e. the value held
  // before any midi_pc_valid update happening in the same cycle.
  preset_ram #(
    .NUM_PRESETS(NUM_PRESETS)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (store_req),
    .waddr (btn_index),
    .wdata (learned_pc),
    .raddr (btn_index),
    .rdata (slot_rdata)
  );

  // Learn the most recent received program change, regardless of FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      learned_pc <= '0;
      learned_ok <= 1'b0;
    end else if (midi_pc_valid) begin
      learned_pc <= midi_pc;
      learned_ok <= 1'b1;
    end
  end

`ifdef PRESET_RUNNING_STATUS_EN
  logic [7:0] last_status;
  logic       last_status_ok;

  // Track the last status byte actually accepted by the transmitter, so a
  // recall can rely on the receiver still holding it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_status    <= '0;
      last_status_ok <= 1'b0;
    end else if ((state == SEND_STATUS) && tx_fire) begin
      last_status    <= tx_data;
      last_status_ok <= 1'b1;
    end
  end

  assign skip_status = last_status_ok && (last_status == STATUS_BYTE);
`else
  assign skip_status = 1'b0;
`endif

  // Sender FSM with registered tx_data/tx_valid/active_slot. The slot value is
  // latched at recall time so a later rewrite cannot change an in-flight send.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_data     <= '0;
      active_slot <= '0;
      latched_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (store_req) begin
            active_slot <= btn_index;
          end else if (recall_req) begin
            latched_val <= slot_rdata;
            active_slot <= btn_index;
            tx_valid    <= 1'b1;
            if (skip_status) begin
              state   <= SEND_DATA;
              tx_data <= {1'b0, slot_rdata};
            end else begin
              state   <= SEND_STATUS;
              tx_data <= STATUS_BYTE;
            end
          end
        end
        SEND_STATUS: begin
          if (tx_fire) begin
            state   <= SEND_DATA;
            tx_data <= {1'b0, latched_val};
          end
        end
        SEND_DATA: begin
          if (tx_fire) begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
          tx_data  <= '0;
        end
      endcase
    end
  end

endmodule
